// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular FIFO of {pc, instr} between fetch and decode.
// Define IF_ID_QUEUE_BYPASS_EN for a same-cycle empty-queue bypass path.
module if_id_queue #(
  parameter int PC_W  = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic [4:0]       out_Rd,
  output logic [4:0]       out_Rn,
  output logic [4:0]       out_Rm,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = PC_W + 32;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty, full;
  logic             push, wr, rd;
  logic             byp, ov;
  logic [EW-1:0]    head;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign byp  = empty && in_valid && !flush;
  assign head = empty ? {in_pc, in_instr} : mem_q[rptr_q];
`else
  assign byp  = 1'b0;
  assign head = mem_q[rptr_q];
`endif

  assign ov = !empty || byp;
  // A bypassed word consumed this cycle never touches storage
  assign wr = push && !(byp && out_ready);
  assign rd = !empty && out_ready && !flush;

  assign out_valid = ov;
  assign out_instr = ov ? head[31:0] : 32'hFFFF_FFFF;
  assign out_pc    = ov ? head[EW-1:32] : '0;
  assign out_Rd    = out_instr[4:0];
  assign out_Rn    = out_instr[9:5];
  assign out_Rm    = out_instr[20:16];
  assign count     = cnt_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr) wptr_d = wptr_q + PW'(1);
      if (rd) rptr_d = rptr_q + PW'(1);
      cnt_d = cnt_q + CNT_W'(wr) - CNT_W'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !reset) mem_q[wptr_q] <= {in_pc, in_instr};
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed pushes queue expected words,
// a negedge monitor pops and compares on every head consumption.
module tb_if_id_queue;

  localparam int PC_W  = 64;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic [PC_W-1:0]  in_pc;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [PC_W-1:0]  out_pc;
  logic [4:0]       out_Rd, out_Rn, out_Rm;
  logic             flush;
  logic [CNT_W-1:0] count;

  int checks   = 0;
  int failures = 0;
  logic [95:0] sb[$];

  always #5 clk = ~clk;

  if_id_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_Rd(out_Rd), .out_Rn(out_Rn), .out_Rm(out_Rm),
    .flush(flush), .count(count)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [63:0] pc, input logic rdy);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
  endtask

  task automatic exp_push(input logic [31:0] ins, input logic [63:0] pc);
    sb.push_back({pc, ins});
  endtask

  // Monitor: every consumed head must match the oldest expected word
  initial begin
    logic [95:0] e;
    forever begin
      @(negedge clk);
      if (!reset && !flush && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected got=%h want=none", out_instr);
        end else begin
          e = sb.pop_front();
          if (out_instr !== e[31:0] || out_pc !== e[95:32]) begin
            failures++;
            $display("FAIL pop_data got=%h@%h want=%h@%h",
                     out_instr, out_pc, e[31:0], e[95:32]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'hFFFF_FFFF);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_Rd", 64'(out_Rd), 64'd31);
    chk("rst_RnRm", 64'({out_Rn, out_Rm}), 64'h3FF);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);

    // Two pushes, decode stalled
    drive(1'b1, 32'h9100_0420, 64'h100, 1'b0);
    exp_push(32'h9100_0420, 64'h100);
    tick();
    drive(1'b1, 32'hAB02_0020, 64'h104, 1'b0);
    exp_push(32'hAB02_0020, 64'h104);
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    #1;
    chk("two_count", 64'(count), 64'd2);
    chk("two_head", 64'(out_instr), 64'h9100_0420);
    chk("two_Rd", 64'(out_Rd), 64'd0);
    chk("two_Rn", 64'(out_Rn), 64'd1);

    // Pop twice
    out_ready = 1'b1;
    tick();
    chk("pop_Rm", 64'(out_Rm), 64'd2);
    chk("pop_head2", 64'(out_instr), 64'hAB02_0020);
    tick();
    out_ready = 1'b0;
    #1;
    chk("pop_empty", 64'(out_valid), 64'd0);

    // Fill to DEPTH
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hC000_0000 + 32'(i), 64'h200 + 64'(4 * i), 1'b0);
      exp_push(32'hC000_0000 + 32'(i), 64'h200 + 64'(4 * i));
      tick();
    end
    drive(1'b1, 32'hC000_0004, 64'h210, 1'b1);
    #1;
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    tick();
    chk("afterpop_count", 64'(count), 64'd3);
    chk("afterpop_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    exp_push(32'hC000_0004, 64'h210);
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b1);
    #1;
    chk("refill_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b0;
    #1;
    chk("drain_count", 64'(count), 64'd0);

    // Flush with three entries and a pending push
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hD000_0000 + 32'(i), 64'h300 + 64'(4 * i), 1'b0);
      tick();
    end
    drive(1'b1, 32'hD000_0003, 64'h30C, 1'b1);
    flush = 1'b1;
    #1;
    chk("pre_flush_count", 64'(count), 64'd3);
    chk("flush_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    #1;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 32'hE000_0000, 64'h400, 1'b1);
    exp_push(32'hE000_0000, 64'h400);
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b1);
    tick();
    out_ready = 1'b0;
    #1;
    chk("post_flush_count", 64'(count), 64'd0);

    // Mid-stream reset with two entries
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'hF000_0000 + 32'(i), 64'h500 + 64'(4 * i), 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    #1;
    chk("pre_rst_count", 64'(count), 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);

    // Empty queue, push with decode ready
    drive(1'b1, 32'h1234_5678, 64'h600, 1'b1);
    exp_push(32'h1234_5678, 64'h600);
    #1;
`ifdef IF_ID_QUEUE_BYPASS_EN
    chk("byp_valid0", 64'(out_valid), 64'd1);
    chk("byp_instr0", 64'(out_instr), 64'h1234_5678);
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b1);
    #1;
    chk("byp_count1", 64'(count), 64'd0);
    chk("byp_valid1", 64'(out_valid), 64'd0);
`else
    chk("lat_valid0", 64'(out_valid), 64'd0);
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b1);
    #1;
    chk("lat_valid1", 64'(out_valid), 64'd1);
    chk("lat_instr1", 64'(out_instr), 64'h1234_5678);
`endif
    tick();
    out_ready = 1'b0;
    #1;
    chk("end_count", 64'(count), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter PC_W, default 64, meaning width of the captured program counter.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of queue entries; legal values are powers of two from 2 to 16.
REQ-003 SHALL have parameter CNT_W, default $clog2(DEPTH)+1, meaning width of the occupancy count.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  fetch presents an instruction.
REQ-007 SHALL have port in_instr  input  32  fetched instruction word.
REQ-008 SHALL have port in_pc  input  PC_W  address of in_instr.
REQ-009 SHALL have port in_ready  output  1  queue accepts a push this cycle.
REQ-010 SHALL have port out_valid  output  1  head entry is valid for decode.
REQ-011 SHALL have port out_ready  input  1  decode consumes the head this cycle.
REQ-012 SHALL have port out_instr  output  32  head instruction; 32'hFFFF_FFFF (bubble) when out_valid=0.
REQ-013 SHALL have port out_pc  output  PC_W  head PC; 0 when out_valid=0.
REQ-014 SHALL have ports out_Rd, out_Rn, out_Rm  output  5 each  out_instr[4:0], [9:5], [20:16]; 5'b11111 when out_valid=0.
REQ-015 SHALL have port flush  input  1  discard all entries (branch redirect).
REQ-016 SHALL have port count  output  CNT_W  current number of valid entries.

Function
REQ-017 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL equal (count != DEPTH) && !flush; in_ready SHALL NOT depend on out_ready.
REQ-019 Entries SHALL be stored as {in_pc, in_instr} in a circular buffer with read/write pointers wrapping from DEPTH-1 to 0.
REQ-020 out_valid SHALL equal (count != 0), and the outputs SHALL reflect the oldest entry, so that order is strictly FIFO.
REQ-021 Latency without bypass SHALL be one cycle: a push at edge N SHALL become visible at the head after edge N.
REQ-022 On a simultaneous push and pop with 0 < count < DEPTH, count SHALL be unchanged and both pointers SHALL advance.
REQ-023 When full, in_ready SHALL be 0, so a same-cycle pop frees the slot only for the following cycle.
REQ-024 Flush SHALL take priority over push and pop: at the next edge, count SHALL be 0, both pointers SHALL be 0, and out_valid SHALL be 0; input data in the flush cycle SHALL be dropped.
REQ-025 count SHALL never exceed DEPTH or underflow; pops while empty and pushes while full SHALL be ignored.

Reset
REQ-026 Reset SHALL override flush and all handshakes.
REQ-027 At the edge where reset is sampled high, the block SHALL clear count and both pointers.
REQ-028 After reset, outputs SHALL read out_valid=0, out_instr=32'hFFFF_FFFF, out_pc=0, and out_Rd/Rn/Rm=5'b11111.
REQ-029 After reset, in_ready SHALL be 1 and count SHALL be 0.
REQ-030 Storage contents need not be cleared by reset.
REQ-031 Reset asserted mid-stream SHALL discard all entries.

Configuration
REQ-032 Macro IF_ID_QUEUE_BYPASS_EN, when defined, SHALL enable a combinational path when count==0, in_valid=1 and flush=0.
REQ-033 With IF_ID_QUEUE_BYPASS_EN defined, out_valid SHALL be 1 and the outputs SHALL carry in_instr/in_pc in that same cycle.
REQ-034 With IF_ID_QUEUE_BYPASS_EN defined, if out_ready=1 the word SHALL be consumed without being written into storage and count SHALL stay 0; otherwise it SHALL be stored normally.
REQ-035 With IF_ID_QUEUE_BYPASS_EN undefined, no path from in_* to out_* SHALL exist, and latency SHALL be exactly as specified in REQ-021.

Verification
REQ-036 The bench SHALL apply reset, then idle -> out_valid=0, out_instr=32'hFFFF_FFFF, out_Rd=31, in_ready=1, count=0.
REQ-037 The bench SHALL push 0x91000420 @pc 0x100, then 0xAB020020 @pc 0x104 with out_ready=0 -> count=2, head 0x91000420, out_Rd=0, out_Rn=1.
REQ-038 The bench SHALL then pop twice -> in order 0xAB020020 with out_Rm=2; then out_valid=0.
REQ-039 The bench SHALL fill to DEPTH=4 -> in_ready=0; it SHALL then hold in_valid=1 and pop one -> no push that cycle, push accepted next cycle, count back to 4, order preserved across pointer wrap.
REQ-040 The bench SHALL apply flush with count=3, in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, and the flush-cycle word absent from all later output.
REQ-041 The bench SHALL assert reset mid-stream with count=2 -> count=0 next cycle; for an empty queue with push and out_ready=1, bypass-enabled builds SHALL give out_valid=1 the same cycle with count staying 0, and bypass-disabled builds SHALL give out_valid=1 one cycle later.
